mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit for the MIPS datapath, which drives it with the A/B register values and MULT/DIV decoded by the control unit. The unit latches both operands on a start pulse and iterates for 32 cycles: Booth radix-2 for multiply, restoring division on magnitudes for divide. It writes the result into internal HI/LO registers, which the CPU reads through the MemToReg mux for MFHI/MFLO. The control unit holds its state machine on `busy` and advances on `done`.

---
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: Booth radix-2 multiply and restoring divide,
// 32 iterations each, results held in HI/LO until the next completed operation.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int DATA_W = 32;
    localparam logic [5:0] ITERS = 6'd32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                   r_state;
    logic [5:0]               r_cnt;
    // Upper accumulator carries one guard bit so M = -2^31 does not overflow.
    logic signed [DATA_W:0]   r_phi;
    logic [DATA_W-1:0]        r_plo;
    logic                     r_q1;
    logic [DATA_W-1:0]        r_m;
    logic                     r_neg_q;
    logic                     r_neg_r;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_dz;
    logic [DATA_W-1:0]        r_hi;
    logic [DATA_W-1:0]        r_lo;

    logic signed [DATA_W:0]   w_m_ext;
    logic signed [DATA_W:0]   w_booth_sum;
    logic [DATA_W:0]          w_rem_shift;
    logic [DATA_W:0]          w_rem_diff;
    logic                     w_last;

    function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [DATA_W-1:0] f_apply_sign(input logic [DATA_W-1:0] mag,
                                                       input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    always_comb begin
        w_m_ext     = $signed({r_m[DATA_W-1], r_m});
        w_booth_sum = r_phi;
        case ({r_plo[0], r_q1})
            2'b01:   w_booth_sum = r_phi + w_m_ext;
            2'b10:   w_booth_sum = r_phi - w_m_ext;
            default: w_booth_sum = r_phi;
        endcase
        // Divide reuses the accumulator: r_phi[31:0] is R, r_plo is Q.
        w_rem_shift = {r_phi[DATA_W-1:0], r_plo[DATA_W-1]};
        w_rem_diff  = w_rem_shift - {1'b0, r_m};
    end

    assign w_last = (r_cnt == ITERS);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_phi  <= '0;
                        r_q1   <= 1'b0;
                        if (!op) begin
                            r_m     <= A;
                            r_plo   <= B;
                            r_state <= S_MULT;
                        end else begin
                            r_m     <= f_mag(B);
                            r_plo   <= f_mag(A);
                            r_neg_q <= A[DATA_W-1] ^ B[DATA_W-1];
                            r_neg_r <= A[DATA_W-1];
                            r_state <= (B == '0) ? S_FINISH : S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    if (w_last) begin
                        r_hi    <= r_phi[DATA_W-1:0];
                        r_lo    <= r_plo;
                        r_done  <= 1'b1;
                        r_dz    <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        r_phi <= w_booth_sum >>> 1;
                        r_plo <= {w_booth_sum[0], r_plo[DATA_W-1:1]};
                        r_q1  <= r_plo[0];
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (w_last) begin
                        r_hi    <= f_apply_sign(r_phi[DATA_W-1:0], r_neg_r);
                        r_lo    <= f_apply_sign(r_plo, r_neg_q);
                        r_done  <= 1'b1;
                        r_dz    <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        if (!w_rem_diff[DATA_W]) begin
                            r_phi <= {1'b0, w_rem_diff[DATA_W-1:0]};
                            r_plo <= {r_plo[DATA_W-2:0], 1'b1};
                        end else begin
                            r_phi <= {1'b0, w_rem_shift[DATA_W-1:0]};
                            r_plo <= {r_plo[DATA_W-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_FINISH: begin
                    // Entered without done only from the divide-by-zero shortcut.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_dz    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        r_dz   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle model built on 64-bit arithmetic plus directed
// vectors with hand-computed results, latencies and control corner cases.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_dz   = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          m_left = 0;
    logic [64:0] pend   = '0;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {div_zero, hi, lo} straight from signed 64-bit arithmetic.
    function automatic logic [64:0] model_calc(input logic o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = sa * sb;
            return {1'b0, p[63:32], p[31:0]};
        end
        if (sb == 0) return {1'b1, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_dz   <= pend[64];
                if (!pend[64]) begin
                    m_hi <= pend[63:32];
                    m_lo <= pend[31:0];
                end
            end
        end else if (start) begin
            m_busy <= 1'b1;
            pend   <= model_calc(op, A, B);
            m_left <= (op && B == 32'd0) ? 1 : 33;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_dz",   32'(div_zero), 32'(m_dz));
            check("cyc_hi",   hi, m_hi);
            check("cyc_lo",   lo, m_lo);
        end
    end

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez,
                          input int elat, input int poke);
        int n;
        bit got;
        @(posedge clock);
        #2 start = 1'b1; op = o; A = a; B = b;
        @(posedge clock);
        #2 start = 1'b0; A = $urandom; B = $urandom;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clock);
            n++;
            #1;
            if (done) got = 1'b1;
            else if (n == poke) begin
                #1 start = 1'b1; op = 1'b0; A = 32'd1; B = 32'd1;
            end else begin
                #1 start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(elat));
        check("res_hi", hi, eh);
        check("res_lo", lo, el);
        check("res_dz", 32'(div_zero), 32'(ez));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
        @(posedge clock);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        #1 reset = 1'b1;

        run_op(1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, -1);
        run_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, -1);
        run_op(1'b0, 32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE, 1'b0, 33, -1);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, -1);
        run_op(1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, -1);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, -1);
        run_op(1'b0, 32'd5,        32'd5,        32'h00000000, 32'd25,       1'b0, 33, -1);
        run_op(1'b1, 32'd9,        32'd0,        32'h00000000, 32'd25,       1'b1, 1,  -1);
        // Second start at cycle 10 must be ignored.
        run_op(1'b0, 32'd100,      32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFFD8F0, 1'b0, 33, 9);

        // Start raised during the done cycle is dropped.
        #1 start = 1'b1; op = 1'b0; A = 32'd2; B = 32'd2;
        @(posedge clock);
        #1 start = 1'b0;
        check("fin_start_ignored", 32'(busy), 32'd0);

        // Reset at cycle 15 of a divide.
        @(posedge clock);
        #2 start = 1'b1; op = 1'b1; A = 32'd1000; B = 32'd7;
        @(posedge clock);
        #2 start = 1'b0;
        repeat (14) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        #1 reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        run_op(1'b0, 32'd3, 32'd4, 32'h00000000, 32'd12, 1'b0, 33, -1);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
